// File: rtl/rooth_mem_arb_pkg.sv
// Shared constants for the rooth single-port memory arbiter.
// Master indices select bits of the one-hot response owner; owner FSM
// encodings are kept as plain constants for compatibility with older code.
package rooth_mem_arb_pkg;

  localparam int MST_DBG  = 0;
  localparam int MST_LSU  = 1;
  localparam int MST_IFU  = 2;

  localparam int ROOTH_AW = 14;

  localparam logic [0:0] ST_OPEN   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

endpackage

// File: rtl/rooth_mem_arb_rr_pick2.sv
// Two-way round-robin pick between the load/store unit (req1) and the
// instruction fetch (req2).
//   clk, rst_n  : clock, async active-low reset
//   pick_en     : normal round-robin arbitration allowed this cycle
//   force2      : grant req2 unconditionally (starvation override)
//   req1, req2  : requests
//   gnt1, gnt2  : grants, at most one high
// The pointer moves to the other master after either one is granted,
// including a forced grant, so the refused side goes first next time.
module rooth_rr_pick2 (
  input  logic clk,
  input  logic rst_n,
  input  logic pick_en,
  input  logic force2,
  input  logic req1,
  input  logic req2,
  output logic gnt1,
  output logic gnt2
);

  logic rr_q;

  assign gnt1 = pick_en & req1 & (~rr_q | ~req2);
  assign gnt2 = force2 | (pick_en & req2 & (rr_q | ~req1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else if (gnt1) begin
      rr_q <= 1'b1;
    end else if (gnt2) begin
      rr_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rooth_mem_arb.sv
// Arbiter for one single-port synchronous SRAM (1-cycle read latency)
// shared by M0 (debug loader), M1 (load/store unit), M2 (instruction fetch).
//   clk, rst_n              : clock, async active-low reset
//   mN_req/we/addr          : request, write flag, word address
//   m0/m1 wdata/wstrb       : write data and byte enables
//   m0_lock                 : M0 keeps exclusive ownership while high
//   mN_gnt                  : combinational grant, one per cycle at most
//   mN_rvalid, rdata        : response one cycle after the grant
//   ram_*                   : SRAM request fields, ram_rdata returned data
//
// Owner FSM
//   state     | meaning
//   ST_OPEN   | normal priority: starved M2, then M0, then M1/M2 round-robin
//   ST_LOCKED | M0 last granted with m0_lock; only M0 may be granted
module rooth_mem_arb
  import rooth_mem_arb_pkg::*;
#(
  parameter int AW         = ROOTH_AW,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_wstrb,
  input  logic            m0_lock,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [AW-1:0]   m1_addr,
  input  logic [DW-1:0]   m1_wdata,
  input  logic [DW/8-1:0] m1_wstrb,
  input  logic            m2_req,
  input  logic            m2_we,
  input  logic [AW-1:0]   m2_addr,
  output logic            m0_gnt,
  output logic            m1_gnt,
  output logic            m2_gnt,
  output logic            m0_rvalid,
  output logic            m1_rvalid,
  output logic            m2_rvalid,
  output logic [DW-1:0]   rdata,
  output logic            ram_ce,
  output logic            ram_we,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  output logic [DW/8-1:0] ram_wstrb,
  input  logic [DW-1:0]   ram_rdata
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] starve_cnt;
  logic [2:0]    rsp_id;
  logic          locked_eff, starve_hit, force_m2, pick_en;

  // Dropping m0_lock releases ownership in the same cycle.
  assign locked_eff = (state_q == ST_LOCKED) && m0_lock;
  assign starve_hit = (starve_cnt == CW'(STARVE_MAX));

  // Grants are gated by rst_n so nothing reaches the SRAM during reset.
  assign force_m2 = rst_n & ~locked_eff & starve_hit & m2_req;
  assign m0_gnt   = rst_n & m0_req & ~force_m2;
  assign pick_en  = rst_n & ~locked_eff & ~force_m2 & ~m0_req;

  rooth_rr_pick2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .pick_en (pick_en),
    .force2  (force_m2),
    .req1    (m1_req),
    .req2    (m2_req),
    .gnt1    (m1_gnt),
    .gnt2    (m2_gnt)
  );

  assign ram_ce = m0_gnt | m1_gnt | m2_gnt;

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wstrb = '0;
    if (m0_gnt) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_wdata = m0_wdata;
      ram_wstrb = m0_wstrb;
    end else if (m1_gnt) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_wdata = m1_wdata;
      ram_wstrb = m1_wstrb;
    end else if (m2_gnt) begin
      // Fetch has no write data; zero strobes keep a stray m2_we harmless.
      ram_we    = m2_we;
      ram_addr  = m2_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OPEN:   if (m0_gnt && m0_lock) state_d = ST_LOCKED;
      ST_LOCKED: if (!m0_lock)          state_d = ST_OPEN;
      default:   state_d = ST_OPEN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OPEN;
      starve_cnt <= '0;
      rsp_id     <= '0;
    end else begin
      state_q <= state_d;
      rsp_id  <= {m2_gnt, m1_gnt, m0_gnt};
      // The loader legitimately halts the core, so a locked cycle does not
      // count towards fetch starvation.
      if (m2_gnt || !m2_req) begin
        starve_cnt <= '0;
      end else if (!locked_eff && !starve_hit) begin
        starve_cnt <= starve_cnt + CW'(1);
      end
    end
  end

  assign m0_rvalid = rsp_id[MST_DBG];
  assign m1_rvalid = rsp_id[MST_LSU];
  assign m2_rvalid = rsp_id[MST_IFU];
  assign rdata     = ram_rdata;

endmodule

// File: tb/tb_rooth_mem_arb.sv
module tb_rooth_mem_arb;

  localparam int AW = 14;
  localparam int DW = 32;

  localparam logic [31:0] D_M0 = 32'h5555_AAAA;
  localparam logic [31:0] D_M1 = 32'h2222_0020;
  localparam logic [31:0] D_M2 = 32'h1111_0010;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            m0_req = 0, m0_we = 0, m0_lock = 0;
  logic [AW-1:0]   m0_addr = 14'h5;
  logic [DW-1:0]   m0_wdata = '0;
  logic [DW/8-1:0] m0_wstrb = '0;
  logic            m1_req = 0, m1_we = 0;
  logic [AW-1:0]   m1_addr = 14'h20;
  logic [DW-1:0]   m1_wdata = '0;
  logic [DW/8-1:0] m1_wstrb = '0;
  logic            m2_req = 0, m2_we = 0;
  logic [AW-1:0]   m2_addr = 14'h10;
  logic            m0_gnt, m1_gnt, m2_gnt;
  logic            m0_rvalid, m1_rvalid, m2_rvalid;
  logic [DW-1:0]   rdata;
  logic            ram_ce, ram_we;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_wdata;
  logic [DW/8-1:0] ram_wstrb;
  logic [DW-1:0]   ram_rdata = '0;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  rooth_mem_arb #(.AW(AW), .DW(DW), .STARVE_MAX(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_wstrb(m0_wstrb), .m0_lock(m0_lock),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_wstrb(m1_wstrb),
    .m2_req(m2_req), .m2_we(m2_we), .m2_addr(m2_addr),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m2_gnt(m2_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m2_rvalid(m2_rvalid),
    .rdata(rdata),
    .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Write-first SRAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_ce && ram_we) begin
      for (int b = 0; b < DW/8; b++)
        if (ram_wstrb[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
    end
    if (ram_ce && !ram_we) ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] rd_of(input logic [2:0] rv);
    case (rv)
      3'b001:  return D_M0;
      3'b010:  return D_M1;
      default: return D_M2;
    endcase
  endfunction

  typedef struct {
    logic       m0r;
    logic       m0l;
    logic       m1r;
    logic       m2r;
    logic [2:0] eg;
    logic [2:0] ev;
  } vec_t;

  vec_t vecs [13];
  logic seen;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < (1<<AW); a++) mem[a] = 32'(a);
    mem[14'h5]  = D_M0;
    mem[14'h20] = D_M1;
    mem[14'h10] = D_M2;

    // {m0_req, m0_lock, m1_req, m2_req, exp gnt {2,1,0}, exp rvalid {2,1,0}}
    vecs[0]  = '{0, 0, 0, 1, 3'b100, 3'b000};
    vecs[1]  = '{0, 0, 0, 1, 3'b100, 3'b100};
    vecs[2]  = '{0, 0, 0, 1, 3'b100, 3'b100};
    vecs[3]  = '{0, 0, 0, 1, 3'b100, 3'b100};
    vecs[4]  = '{0, 0, 1, 1, 3'b010, 3'b100};
    vecs[5]  = '{0, 0, 1, 1, 3'b100, 3'b010};
    vecs[6]  = '{0, 0, 1, 1, 3'b010, 3'b100};
    vecs[7]  = '{0, 0, 1, 1, 3'b100, 3'b010};
    vecs[8]  = '{1, 0, 1, 1, 3'b001, 3'b100};
    vecs[9]  = '{0, 0, 0, 0, 3'b000, 3'b001};
    vecs[10] = '{0, 0, 1, 0, 3'b010, 3'b000};
    vecs[11] = '{0, 0, 1, 1, 3'b100, 3'b010};
    vecs[12] = '{0, 0, 0, 0, 3'b000, 3'b100};

    // Reset: requests present but gated.
    m0_req = 1; m2_req = 1; m1_req = 1;
    #23;
    chk("rst_gnt",    {29'd0, m2_gnt, m1_gnt, m0_gnt}, 32'd0);
    chk("rst_rvalid", {29'd0, m2_rvalid, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_ce",     {31'd0, ram_ce}, 32'd0);
    chk("rst_starve", 32'(dut.starve_cnt), 32'd0);
    @(negedge clk);
    m0_req = 0; m1_req = 0; m2_req = 0;
    rst_n = 1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      m0_req = vecs[i].m0r; m0_lock = vecs[i].m0l;
      m1_req = vecs[i].m1r; m2_req = vecs[i].m2r;
      #1;
      chk($sformatf("v%0d_gnt", i), {29'd0, m2_gnt, m1_gnt, m0_gnt}, {29'd0, vecs[i].eg});
      chk($sformatf("v%0d_rvalid", i), {29'd0, m2_rvalid, m1_rvalid, m0_rvalid}, {29'd0, vecs[i].ev});
      chk($sformatf("v%0d_ce", i), {31'd0, ram_ce}, {31'd0, |vecs[i].eg});
      if (vecs[i].ev != 3'b000)
        chk($sformatf("v%0d_rdata", i), rdata, rd_of(vecs[i].ev));
    end

    // Partial write by M0 followed by M1 read of the same word.
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_wdata = 32'hDEAD_BEEF; m0_wstrb = 4'b0011;
    #1;
    chk("wr_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("wr_ram_we", {31'd0, ram_we}, 32'd1);
    chk("wr_ram_wstrb", {28'd0, ram_wstrb}, 32'h3);
    @(negedge clk);
    m0_req = 0; m0_we = 0; m0_wstrb = '0;
    m1_req = 1; m1_addr = 14'h5;
    #1;
    chk("raw_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    chk("raw_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    @(negedge clk);
    m1_req = 0; m1_addr = 14'h20;
    #1;
    chk("raw_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
    chk("raw_rdata", rdata, 32'h5555_BEEF);

    // Lock: M2 must wait and not accumulate starvation.
    @(negedge clk);
    m0_req = 1; m0_lock = 1;
    #1;
    chk("lock_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      m2_req = 1;
      m0_req = (c % 4 == 3);
      #1;
      chk($sformatf("lock%0d_m2_gnt", c), {31'd0, m2_gnt}, 32'd0);
      chk($sformatf("lock%0d_starve", c), 32'(dut.starve_cnt), 32'd0);
      if (m0_req) chk($sformatf("lock%0d_m0_gnt", c), {31'd0, m0_gnt}, 32'd1);
    end
    @(negedge clk);
    m0_lock = 0; m0_req = 0;
    seen = 0;
    for (int c = 0; c < 2 && !seen; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (m2_gnt) seen = 1;
    end
    chk("unlock_m2_gnt_within2", {31'd0, seen}, 32'd1);
    @(negedge clk);
    m2_req = 0;

    // Starvation: M0 hogs, M2 forced after 8 refusals.
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      logic [2:0] eg;
      @(negedge clk);
      m1_req = 1; m2_req = 1; m0_req = (k < 10);
      #1;
      eg = (k == 8 || k == 11) ? 3'b100 : (k == 10) ? 3'b010 : 3'b001;
      chk($sformatf("stv%0d_gnt", k), {29'd0, m2_gnt, m1_gnt, m0_gnt}, {29'd0, eg});
      if (k == 8) chk("stv_cnt_at_force", 32'(dut.starve_cnt), 32'd8);
      if (k == 9) chk("stv_cnt_after_force", 32'(dut.starve_cnt), 32'd0);
    end
    @(negedge clk);
    m0_req = 0; m1_req = 0; m2_req = 0;

    // Reset hit right after an M1 read grant drops the response.
    @(negedge clk);
    m1_req = 1;
    #1;
    chk("rst_seq_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("rst_seq_rvalid", {29'd0, m2_rvalid, m1_rvalid, m0_rvalid}, 32'd0);
    chk("rst_seq_gnt", {29'd0, m2_gnt, m1_gnt, m0_gnt}, 32'd0);
    chk("rst_seq_ce", {31'd0, ram_ce}, 32'd0);
    @(negedge clk);
    m1_req = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_rel_rvalid", {29'd0, m2_rvalid, m1_rvalid, m0_rvalid}, 32'd0);
    @(negedge clk);
    #1;
    chk("rst_rel_rvalid2", {29'd0, m2_rvalid, m1_rvalid, m0_rvalid}, 32'd0);
    @(negedge clk);
    m1_req = 1;
    #1;
    chk("post_rst_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    @(negedge clk);
    m1_req = 0;
    #1;
    chk("post_rst_m1_rvalid", {31'd0, m1_rvalid}, 32'd1);
    chk("post_rst_rdata", rdata, D_M1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
